// File: rtl/pe_traffic_node.sv
// -----------------------------------------------------------------------------
// pe_traffic_node
//
// Processing element that sits on a router's local port. It injects
// single-flit packets under credit-based flow control and sinks ejected flits,
// exposing the last received payload and a running receive count. Used as the
// traffic source/sink for NoC bring-up and regression.
//
// Flit format (20 bits):
//   [19:18] dest cluster, [17:16] dest local, [15:0] payload
//   payload [15:12] = source ID {my_cluster, my_local}, [11:0] = sequence no.
//
// Parameters:
//   CREDITS   depth of the router's local input buffer (initial/max credits)
//   NUM_PKTS  packets injected per start pulse (1..4095)
//   GAP       idle cycles between successive injections (0..255)
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   my_cluster  this node's cluster ID
//   my_local    this node's local ID
//   start       one-cycle pulse starting an injection run (IDLE/DONE only)
//   datain      ejected flit from the router
//   in_valid    datain valid; accepted every cycle, never backpressured
//   ci          credit return, one pulse per freed router slot
//   dataout     injected flit (holds its value when out_valid is low)
//   out_valid   dataout valid
//   read        payload of the last accepted received flit
//   rx_count    received-flit counter, wraps 4095 -> 0
//   done        high while the injector is in DONE
//   credit_err  sticky: ci arrived while credits were already full
//   misroute    (PE_CHECK_EN only) sticky: a received flit was not addressed
//               to this node, or claims this node as its source
//
// Build option:
//   PE_CHECK_EN  when defined, adds the misroute port and its checker.
// -----------------------------------------------------------------------------
module pe_traffic_node #(
    parameter int CREDITS  = 4,
    parameter int NUM_PKTS = 16,
    parameter int GAP      = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  my_cluster,
    input  logic [1:0]  my_local,
    input  logic        start,
    input  logic [19:0] datain,
    input  logic        in_valid,
    input  logic        ci,
    output logic [19:0] dataout,
    output logic        out_valid,
    output logic [15:0] read,
    output logic [11:0] rx_count,
    output logic        done,
    output logic        credit_err
`ifdef PE_CHECK_EN
    ,
    output logic        misroute
`endif
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam int CW = $clog2(CREDITS + 1);

    localparam logic [CW-1:0] CRED_MAX  = CW'(CREDITS);
    localparam logic [CW-1:0] CRED_ONE  = CW'(1);
    localparam logic [11:0]   SEQ_LAST  = 12'(NUM_PKTS - 1);
    localparam logic [7:0]    GAP_LOAD  = 8'(GAP);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]    r_state;
    logic [CW-1:0] r_credits;
    logic [11:0]   r_seq;
    logic [3:0]    r_dest;
    logic [7:0]    r_gap;
    logic [19:0]   r_dataout;
    logic          r_out_valid;
    logic          r_credit_err;
    logic [15:0]   r_read;
    logic [11:0]   r_rx_count;

    // -------------------------------------------------------------------------
    // Combinational decode
    // -------------------------------------------------------------------------
    logic [3:0] w_own_id;
    logic       w_start_ok;
    logic       w_send;
    logic       w_last;
    logic [3:0] w_dest_inc;
    logic [3:0] w_dest_next;
    logic [1:0] w_state_next;

    assign w_own_id   = {my_cluster, my_local};
    assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    // A send happens on the SEND-state edge whenever at least one router slot
    // is free; the flit becomes visible on dataout the following cycle.
    assign w_send = (r_state == ST_SEND) && (r_credits != '0);
    assign w_last = (r_seq == SEQ_LAST);

    // Advance the destination, skipping our own ID so we never target self.
    assign w_dest_inc  = r_dest + 4'd1;
    assign w_dest_next = (w_dest_inc == w_own_id) ? (r_dest + 4'd2) : w_dest_inc;

    // NOTE: every signal assigned in always_comb gets a default first so that
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) w_state_next = ST_SEND;
            end
            ST_SEND: begin
                if (w_send) begin
                    if (w_last)          w_state_next = ST_DONE;
                    else if (GAP == 0)   w_state_next = ST_SEND;
                    else                 w_state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                // Counter was loaded with GAP on the send edge; leaving at 1
                // yields exactly GAP idle output cycles between flits.
                if (r_gap <= 8'd1) w_state_next = ST_SEND;
            end
            ST_DONE: begin
                if (w_start_ok) w_state_next = ST_SEND;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Injection FSM and datapath
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_seq       <= '0;
            r_dest      <= '0;
            r_gap       <= '0;
            r_dataout   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_out_valid <= 1'b0;

            if (w_start_ok) begin
                r_seq  <= '0;
                r_dest <= w_own_id + 4'd1;
            end else if (w_send) begin
                r_dataout   <= {r_dest, w_own_id, r_seq};
                r_out_valid <= 1'b1;
                r_seq       <= r_seq + 12'd1;
                r_dest      <= w_dest_next;
                r_gap       <= GAP_LOAD;
            end else if (r_state == ST_GAP) begin
                r_gap <= r_gap - 8'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Credit counter: send consumes, ci returns; both together cancel out.
    // Credits survive a DONE -> SEND restart; only reset refills them.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_credits    <= CRED_MAX;
            r_credit_err <= 1'b0;
        end else begin
            if (w_send && !ci) begin
                r_credits <= r_credits - CRED_ONE;
            end else if (ci && !w_send) begin
                if (r_credits == CRED_MAX) r_credit_err <= 1'b1;
                else                       r_credits    <= r_credits + CRED_ONE;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Receive path: independent of injection, never backpressures.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_read     <= '0;
            r_rx_count <= '0;
        end else if (in_valid) begin
            r_read     <= datain[15:0];
            r_rx_count <= r_rx_count + 12'd1;
        end
    end

`ifdef PE_CHECK_EN
    // Flag flits addressed elsewhere or claiming to originate from this node.
    logic r_misroute;
    logic w_bad_flit;

    assign w_bad_flit = (datain[19:16] != w_own_id) || (datain[15:12] == w_own_id);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_misroute <= 1'b0;
        end else if (in_valid && w_bad_flit) begin
            r_misroute <= 1'b1;
        end
    end

    assign misroute = r_misroute;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign dataout    = r_dataout;
    assign out_valid  = r_out_valid;
    assign read       = r_read;
    assign rx_count   = r_rx_count;
    assign done       = (r_state == ST_DONE);
    assign credit_err = r_credit_err;

endmodule

// File: tb/tb_pe_traffic_node.sv
// -----------------------------------------------------------------------------
// tb_pe_traffic_node
//
// Scoreboard bench for pe_traffic_node. Two instances:
//   u_dut_a : NUM_PKTS=3,  GAP=2 (spaced injection, receive, credit error)
//   u_dut_b : NUM_PKTS=16, GAP=0 (back-to-back, credit stall, dest sweep)
// The main process pushes expected flits into per-instance queues; monitor
// processes pop and compare whenever out_valid is seen on the falling edge.
// -----------------------------------------------------------------------------
module tb_pe_traffic_node;

    typedef struct {
        logic [19:0] flit;
        int          gap;   // expected cycles since previous flit, -1 = any
    } exp_t;

    logic clk;
    int   cyc;
    int   n_chk;
    int   n_err;

    // Instance A signals
    logic        a_rst, a_start, a_in_valid, a_ci_echo, a_ci_man, a_echo_en;
    logic [1:0]  a_cluster, a_local, a_pipe;
    logic [19:0] a_datain, a_dataout;
    logic        a_out_valid, a_done, a_credit_err;
    logic [15:0] a_read;
    logic [11:0] a_rx_count;
    exp_t        a_q[$];
    int          a_ov_cnt;

    // Instance B signals
    logic        b_rst, b_start, b_in_valid, b_ci_echo, b_ci_man, b_echo_en;
    logic [1:0]  b_cluster, b_local, b_pipe;
    logic [19:0] b_datain, b_dataout;
    logic        b_out_valid, b_done, b_credit_err;
    logic [15:0] b_read;
    logic [11:0] b_rx_count;
    exp_t        b_q[$];
    int          b_ov_cnt;

`ifdef PE_CHECK_EN
    logic a_misroute, b_misroute;
`endif

    pe_traffic_node #(.CREDITS(4), .NUM_PKTS(3), .GAP(2)) u_dut_a (
        .clk        (clk),
        .rst        (a_rst),
        .my_cluster (a_cluster),
        .my_local   (a_local),
        .start      (a_start),
        .datain     (a_datain),
        .in_valid   (a_in_valid),
        .ci         (a_ci_echo | a_ci_man),
        .dataout    (a_dataout),
        .out_valid  (a_out_valid),
        .read       (a_read),
        .rx_count   (a_rx_count),
        .done       (a_done),
        .credit_err (a_credit_err)
`ifdef PE_CHECK_EN
        ,
        .misroute   (a_misroute)
`endif
    );

    pe_traffic_node #(.CREDITS(4), .NUM_PKTS(16), .GAP(0)) u_dut_b (
        .clk        (clk),
        .rst        (b_rst),
        .my_cluster (b_cluster),
        .my_local   (b_local),
        .start      (b_start),
        .datain     (b_datain),
        .in_valid   (b_in_valid),
        .ci         (b_ci_echo | b_ci_man),
        .dataout    (b_dataout),
        .out_valid  (b_out_valid),
        .read       (b_read),
        .rx_count   (b_rx_count),
        .done       (b_done),
        .credit_err (b_credit_err)
`ifdef PE_CHECK_EN
        ,
        .misroute   (b_misroute)
`endif
    );

    // -------------------------------------------------------------------------
    // Clock, cycle counter, watchdog
    // -------------------------------------------------------------------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (errors=%0d)", n_err);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // -------------------------------------------------------------------------
    // Credit echo: return one ci pulse about two cycles after each flit seen.
    // -------------------------------------------------------------------------
    initial begin
        a_pipe = '0; b_pipe = '0; a_ci_echo = 1'b0; b_ci_echo = 1'b0;
        forever begin
            @(negedge clk);
            a_pipe    = {a_pipe[0], a_out_valid & a_echo_en};
            a_ci_echo = a_pipe[1];
            b_pipe    = {b_pipe[0], b_out_valid & b_echo_en};
            b_ci_echo = b_pipe[1];
        end
    end

    // -------------------------------------------------------------------------
    // Monitors
    // -------------------------------------------------------------------------
    initial begin
        exp_t e;
        int   last;
        last = 0;
        forever begin
            @(negedge clk);
            if (a_rst && a_out_valid) begin
                a_ov_cnt++;
                check("a_flit_queued", 32'(a_q.size() != 0), 32'd1);
                if (a_q.size() != 0) begin
                    e = a_q.pop_front();
                    check("a_flit", 32'(a_dataout), 32'(e.flit));
                    if (e.gap >= 0) check("a_spacing", 32'(cyc - last), 32'(e.gap));
                end
                last = cyc;
            end
        end
    end

    initial begin
        exp_t e;
        int   last;
        last = 0;
        forever begin
            @(negedge clk);
            if (b_rst && b_out_valid) begin
                b_ov_cnt++;
                check("b_flit_queued", 32'(b_q.size() != 0), 32'd1);
                if (b_q.size() != 0) begin
                    e = b_q.pop_front();
                    check("b_flit", 32'(b_dataout), 32'(e.flit));
                    if (e.gap >= 0) check("b_spacing", 32'(cyc - last), 32'(e.gap));
                end
                last = cyc;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        logic [3:0] d;
        n_chk = 0; n_err = 0; a_ov_cnt = 0; b_ov_cnt = 0;
        a_rst = 1'b0; a_start = 1'b0; a_in_valid = 1'b0; a_ci_man = 1'b0; a_echo_en = 1'b0;
        b_rst = 1'b0; b_start = 1'b0; b_in_valid = 1'b0; b_ci_man = 1'b0; b_echo_en = 1'b0;
        a_datain = '0; b_datain = '0;
        a_cluster = 2'd1; a_local = 2'd2;   // own ID 6
        b_cluster = 2'd1; b_local = 2'd1;   // own ID 5

        // ---- Reset state ----------------------------------------------------
        tick(3);
        check("a_rst_dataout",    32'(a_dataout),    32'h0);
        check("a_rst_out_valid",  32'(a_out_valid),  32'h0);
        check("a_rst_read",       32'(a_read),       32'h0);
        check("a_rst_rx_count",   32'(a_rx_count),   32'h0);
        check("a_rst_done",       32'(a_done),       32'h0);
        check("a_rst_credit_err", 32'(a_credit_err), 32'h0);
        check("b_rst_dataout",    32'(b_dataout),    32'h0);
        check("b_rst_out_valid",  32'(b_out_valid),  32'h0);
        check("b_rst_done",       32'(b_done),       32'h0);
        a_rst = 1'b1; b_rst = 1'b1;

        // ---- Idle without start: no flits for 20 cycles ----------------------
        tick(20);
        check("a_idle_flits", 32'(a_ov_cnt), 32'd0);
        check("b_idle_flits", 32'(b_ov_cnt), 32'd0);
        check("a_idle_done",  32'(a_done),   32'd0);

        // ---- A run 1: own ID 6, 3 packets, GAP=2, credits echoed ------------
        for (int i = 0; i < 3; i++)
            a_q.push_back('{flit: {4'(7 + i), 4'h6, 12'(i)}, gap: (i == 0) ? -1 : 3});
        a_echo_en = 1'b1;
        a_start = 1'b1; tick(1); a_start = 1'b0;
        for (int k = 0; k < 100 && !a_done; k++) tick(1);
        check("a_run1_done", 32'(a_done), 32'd1);
        tick(6);
        check("a_run1_flits", 32'(a_ov_cnt), 32'd3);
        check("a_run1_queue", 32'(a_q.size()), 32'd0);
        check("a_run1_dataout_hold", 32'(a_dataout), 32'h96002);

        // ---- A run 2 from DONE, with concurrent receive ---------------------
        a_ov_cnt = 0;
        for (int i = 0; i < 3; i++)
            a_q.push_back('{flit: {4'(7 + i), 4'h6, 12'(i)}, gap: (i == 0) ? -1 : 3});
        a_start = 1'b1; a_in_valid = 1'b1; a_datain = {4'h6, 16'h1234};
        tick(1);
        a_start = 1'b0; a_datain = {4'h6, 16'hABCD};
        tick(1);
        a_datain = {4'h6, 16'h0F0F};
        tick(1);
        a_in_valid = 1'b0;
        tick(1);
        check("a_rx_read",  32'(a_read),     32'h0F0F);
        check("a_rx_count", 32'(a_rx_count), 32'd3);
        for (int k = 0; k < 100 && !a_done; k++) tick(1);
        check("a_run2_done", 32'(a_done), 32'd1);
        tick(6);
        check("a_run2_flits", 32'(a_ov_cnt), 32'd3);
        check("a_run2_queue", 32'(a_q.size()), 32'd0);

        // ---- Credit overflow at full credits -------------------------------
        check("a_credit_err_clear", 32'(a_credit_err), 32'd0);
        a_ci_man = 1'b1; tick(1); a_ci_man = 1'b0; tick(1);
        check("a_credit_err_set", 32'(a_credit_err), 32'd1);
        tick(5);
        check("a_credit_err_sticky", 32'(a_credit_err), 32'd1);

        // ---- B: own ID 5, GAP=0, no credit return -> 4 flits then stall -----
        for (int i = 0; i < 4; i++)
            b_q.push_back('{flit: {4'(6 + i), 4'h5, 12'(i)}, gap: (i == 0) ? -1 : 1});
        b_start = 1'b1; tick(1); b_start = 1'b0;
        tick(15);
        check("b_stall_flits", 32'(b_ov_cnt), 32'd4);
        check("b_stall_queue", 32'(b_q.size()), 32'd0);
        check("b_stall_done",  32'(b_done), 32'd0);
        b_q.push_back('{flit: {4'hA, 4'h5, 12'd4}, gap: -1});
        b_ci_man = 1'b1; tick(1); b_ci_man = 1'b0;
        tick(10);
        check("b_one_credit_flits", 32'(b_ov_cnt), 32'd5);
        check("b_one_credit_queue", 32'(b_q.size()), 32'd0);

`ifdef PE_CHECK_EN
        // ---- Misroute: flit for node 3 ejected at node 5 --------------------
        check("b_misroute_clear", 32'(b_misroute), 32'd0);
        b_in_valid = 1'b1; b_datain = {4'h3, 16'h0000};
        tick(1);
        b_in_valid = 1'b0;
        tick(1);
        check("b_misroute_set", 32'(b_misroute), 32'd1);
        check("b_misroute_read", 32'(b_rx_count), 32'd1);
        tick(4);
        check("b_misroute_sticky", 32'(b_misroute), 32'd1);
        b_rst = 1'b0; tick(1);
        check("b_misroute_reset", 32'(b_misroute), 32'd0);
        b_rst = 1'b1;
`endif

        // ---- Mid-run reset aborts to IDLE -----------------------------------
        b_rst = 1'b0; tick(2);
        b_cluster = 2'd3; b_local = 2'd3;   // own ID 15
        check("b_abort_done",      32'(b_done),      32'd0);
        check("b_abort_out_valid", 32'(b_out_valid), 32'd0);
        b_rst = 1'b1; tick(1);

        // ---- B: own ID 15 sweep, credits echoed -----------------------------
        b_ov_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            d = (i < 15) ? 4'(i) : 4'h0;
            b_q.push_back('{flit: {d, 4'hF, 12'(i)}, gap: -1});
        end
        b_echo_en = 1'b1;
        b_start = 1'b1; tick(1); b_start = 1'b0;
        for (int k = 0; k < 300 && !b_done; k++) tick(1);
        check("b_sweep_done", 32'(b_done), 32'd1);
        tick(6);
        check("b_sweep_flits", 32'(b_ov_cnt), 32'd16);
        check("b_sweep_queue", 32'(b_q.size()), 32'd0);
        check("b_sweep_credit_err", 32'(b_credit_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pe_traffic_node.md
Name: pe_traffic_node

Overview:
- Processing element that sits directly on a router's local (fifth) port inside a node wrapper.
- Injects single-flit packets into the router under credit-based flow control.
- Sinks ejected flits from the router and exposes the last received payload and a receive count.
- Used as the traffic source/sink for NoC bring-up and regression.

Parameters:
- CREDITS, 4, depth of the router's local input buffer; initial and maximum credit count.
- NUM_PKTS, 16, packets injected per start pulse (1..4095).
- GAP, 3, idle cycles between successive injections (0..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- my_cluster  input  2  this node's cluster ID.
- my_local  input  2  this node's local ID.
- start  input  1  one-cycle pulse that begins an injection run; ignored unless state is IDLE or DONE.
- datain  input  20  ejected flit from the router.
- in_valid  input  1  datain valid.
- ci  input  1  credit return from the router; one pulse per freed slot.
- dataout  output  20  injected flit.
- out_valid  output  1  dataout valid.
- read  output  16  payload of the last accepted received flit.
- rx_count  output  12  received-flit counter; wraps at 4095 -> 0.
- done  output  1  high while state is DONE.
- credit_err  output  1  sticky flag: ci arrived while credits already equal CREDITS.

Behaviour:
- Flit format:
  - [19:18] dest cluster; [17:16] dest local; [15:0] payload.
  - Payload [15:12] = source ID {my_cluster, my_local}; [11:0] = sequence number, starting at 0 each run.
- Reset (rst low, asynchronous): all outputs are 0; state IDLE; credits = CREDITS; seq = 0.
- Destination sequence:
  - dest register loads {my_cluster, my_local}+1 (mod 16) on start.
  - It increments by 1 after each send; if the next value equals own ID it increments by 2 (mod 16).
  - Self is never targeted.
- Credit counter (0..CREDITS):
  - Send decrements; ci increments.
  - Send and ci in the same cycle leave it unchanged.
  - ci at CREDITS saturates and sets credit_err; credit_err clears only on reset.
- FSM:
  - IDLE: start -> SEND.
  - SEND:
    - If credits > 0: drive out_valid = 1 for exactly one cycle with the registered flit; seq++, dest advances.
      - If the sent packet was the NUM_PKTS-th -> DONE.
      - Else if GAP = 0 -> stay in SEND.
      - Else -> GAP_WAIT with gap counter = GAP.
    - If credits = 0: out_valid = 0; hold flit and seq; stay in SEND until credits > 0.
  - GAP_WAIT: count down to 1 -> SEND. Exactly GAP cycles with out_valid = 0 between sends.
  - DONE: done = 1; start -> SEND with seq reset to 0 and dest reloaded. Credits are not reset.
- Output timing:
  - dataout and out_valid are registered: a flit appears the cycle after the SEND decision.
  - out_valid is never high for two consecutive cycles unless GAP = 0 and credits allow.
  - dataout holds its last value when out_valid = 0.
- Receive path:
  - Flit is accepted every cycle in_valid = 1; the PE never backpressures.
  - read <= datain[15:0] and rx_count++ one cycle after acceptance.
  - Receive runs independently of injection, including simultaneous send/receive.
- Reset mid-run: asynchronous abort to IDLE; an in-flight out_valid drops immediately.

Optional Feature:
- Macro: PE_CHECK_EN.
- With PE_CHECK_EN defined:
  - Adds output misroute (1 bit, sticky until reset).
  - Set when an accepted flit has datain[19:16] != {my_cluster, my_local}, or its source field equals own ID.
  - Misrouted flits still update read and rx_count.
- Without it: port absent; no checking logic.

Test Plan:
- Reset then idle: all outputs 0, credits = 4, no out_valid for 20 cycles without start.
- my_cluster=1, my_local=2, NUM_PKTS=3, GAP=2, ci echoed two cycles after each send -> flits 0x7_6000, 0x8_6001, 0x9_6002, each spaced by exactly 2 idle cycles, then done = 1.
- Own ID 5, GAP=0, no ci, NUM_PKTS=16 -> exactly 4 flits on consecutive cycles to dests 6, 7, 8, 9, then a stall; one ci pulse -> exactly one more flit to dest 10.
- Own ID 15, sweep 16 packets with credits returned -> destinations 0..14, then 0; 15 never appears.
- Inject in_valid for 3 cycles with payloads 0x1234, 0xABCD, 0x0F0F, concurrent with sends -> read = 0x0F0F, rx_count = 3; ci at full credits -> credit_err = 1.
- PE_CHECK_EN build: eject a flit with dest field 0x3 to node 0x5 -> misroute = 1 and stays set; reset clears it.
